bram_stream_mover: RTL

Parametrised successor to the Sobel top-level's fixed BRAM0->BRAM1 move path. It streams i_num_cnt words from a source BRAM port to a destination BRAM port at one word per cycle. Source and destination base addresses are programmable, BRAM read latency is configurable, and a per-pixel operation is applied in flight: copy, invert, threshold, or fill. It sits between the host-loaded image BRAM and the working BRAM, ahead of the Sobel datapath.

---
 rtl/sobel_pkg.sv | 24 ++
 rtl/bram_stream_mover_if.sv | 25 ++
 rtl/pixel_op.sv | 23 ++
 rtl/bram_stream_mover.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared encodings for the Sobel front end: pixel op modes, mover FSM states, latency range.
package sobel_pkg;

    localparam logic [1:0] MODE_COPY   = 2'b00;
    localparam logic [1:0] MODE_INVERT = 2'b01;
    localparam logic [1:0] MODE_THRESH = 2'b10;
    localparam logic [1:0] MODE_FILL   = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned RD_LATENCY_MIN = 1;
    localparam int unsigned RD_LATENCY_MAX = 3;

    // Out-of-range latencies are pinned to the nearest legal value.
    function automatic int unsigned clamp_rd_latency(input int unsigned lat);
        if (lat < RD_LATENCY_MIN) return RD_LATENCY_MIN;
        if (lat > RD_LATENCY_MAX) return RD_LATENCY_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/bram_stream_mover_if.sv
// Source/destination BRAM port bundle; master is the mover, slave is the memory side.
interface bram_stream_mover_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  o_src_ce;
    logic [ADDR_WIDTH-1:0] o_src_addr;
    logic [DATA_WIDTH-1:0] i_src_q;
    logic                  o_dst_ce;
    logic                  o_dst_we;
    logic [ADDR_WIDTH-1:0] o_dst_addr;
    logic [DATA_WIDTH-1:0] o_dst_d;

    modport master (
        output o_src_ce, o_src_addr,
        input  i_src_q,
        output o_dst_ce, o_dst_we, o_dst_addr, o_dst_d
    );

    modport slave (
        input  o_src_ce, o_src_addr,
        output i_src_q,
        input  o_dst_ce, o_dst_we, o_dst_addr, o_dst_d
    );
endinterface

// File: rtl/pixel_op.sv
// Combinational per-pixel operation: copy, invert, unsigned threshold, or constant fill.
module pixel_op
    import sobel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [1:0]            i_mode,
    input  logic [DATA_WIDTH-1:0] i_q,
    input  logic [DATA_WIDTH-1:0] i_thresh,
    output logic [DATA_WIDTH-1:0] o_d
);

    always_comb begin
        o_d = i_q;
        unique case (i_mode)
            MODE_COPY:   o_d = i_q;
            MODE_INVERT: o_d = ~i_q;
            MODE_THRESH: o_d = (i_q >= i_thresh) ? '1 : '0;
            MODE_FILL:   o_d = i_thresh;
        endcase
    end

endmodule

// File: rtl/bram_stream_mover.sv
// Streams a programmable block of words from a source BRAM to a destination BRAM,
// one word per cycle, applying a pixel op in flight. All outputs are registered.
module bram_stream_mover
    import sobel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_run,
    input  logic [ADDR_WIDTH-1:0] i_num_cnt,
    input  logic [ADDR_WIDTH-1:0] i_src_base,
    input  logic [ADDR_WIDTH-1:0] i_dst_base,
    input  logic [1:0]            i_mode,
    input  logic [DATA_WIDTH-1:0] i_thresh,
    output logic                  o_idle,
    output logic                  o_read,
    output logic                  o_write,
    output logic                  o_done,
    bram_stream_mover_if.master   bram
);

    localparam int unsigned RdLat = clamp_rd_latency(RD_LATENCY);

    logic [1:0]            r_state, w_state;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt, r_src_base, w_src_base, r_dst_base, w_dst_base;
    logic [ADDR_WIDTH-1:0] r_k, w_k, r_wk, w_wk;
    logic [1:0]            r_mode, w_mode;
    logic [DATA_WIDTH-1:0] r_thresh, w_thresh;
    logic [RdLat-1:0]      r_vld, w_vld;
    logic                  r_idle, w_idle, r_done, w_done;
    logic                  r_src_ce, w_src_ce, r_dst_ce, w_dst_ce;
    logic [ADDR_WIDTH-1:0] r_src_addr, w_src_addr, r_dst_addr, w_dst_addr;
    logic [DATA_WIDTH-1:0] r_dst_d, w_dst_d, w_op_d;

    pixel_op #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_pixel_op (
        .i_mode  (r_mode),
        .i_q     (bram.i_src_q),
        .i_thresh(r_thresh),
        .o_d     (w_op_d)
    );

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_src_base = r_src_base;
        w_dst_base = r_dst_base;
        w_mode     = r_mode;
        w_thresh   = r_thresh;
        w_k        = r_k;
        w_wk       = r_wk;
        w_idle     = 1'b0;
        w_done     = 1'b0;
        w_src_ce   = 1'b0;
        w_src_addr = '0;
        w_dst_ce   = 1'b0;
        w_dst_addr = '0;
        w_dst_d    = '0;

        // A read shown on the port this cycle is captured by the BRAM at this edge.
        w_vld    = r_vld;
        w_vld[0] = r_src_ce;
        for (int unsigned i = 1; i < RdLat; i++) w_vld[i] = r_vld[i-1];

        if (r_vld[RdLat-1]) begin
            w_dst_ce   = 1'b1;
            w_dst_addr = r_dst_base + r_wk;
            w_dst_d    = w_op_d;
            w_wk       = r_wk + ADDR_WIDTH'(1);
        end

        unique case (r_state)
            ST_IDLE: begin
                w_idle = 1'b1;
                if (i_run) begin
                    w_cnt      = i_num_cnt;
                    w_src_base = i_src_base;
                    w_dst_base = i_dst_base;
                    w_mode     = i_mode;
                    w_thresh   = i_thresh;
                    w_wk       = '0;
                    w_idle     = 1'b0;
                    if (i_num_cnt == '0) begin
                        w_state = ST_DONE;
                        w_done  = 1'b1;
                    end else begin
                        // First access goes out straight from the start edge.
                        w_state = ST_READ;
                        w_k     = ADDR_WIDTH'(1);
                        if (i_mode == MODE_FILL) begin
                            w_dst_ce   = 1'b1;
                            w_dst_addr = i_dst_base;
                            w_dst_d    = i_thresh;
                        end else begin
                            w_src_ce   = 1'b1;
                            w_src_addr = i_src_base;
                        end
                    end
                end
            end
            ST_READ: begin
                if (r_k == r_cnt) begin
                    if (r_mode == MODE_FILL) begin
                        w_state = ST_DONE;
                        w_done  = 1'b1;
                    end else begin
                        w_state = ST_DRAIN;
                    end
                end else begin
                    w_k = r_k + ADDR_WIDTH'(1);
                    if (r_mode == MODE_FILL) begin
                        w_dst_ce   = 1'b1;
                        w_dst_addr = r_dst_base + r_k;
                        w_dst_d    = r_thresh;
                    end else begin
                        w_src_ce   = 1'b1;
                        w_src_addr = r_src_base + r_k;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_vld == '0) begin
                    w_state = ST_DONE;
                    w_done  = 1'b1;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_idle  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_src_base <= '0;
            r_dst_base <= '0;
            r_mode     <= MODE_COPY;
            r_thresh   <= '0;
            r_k        <= '0;
            r_wk       <= '0;
            r_vld      <= '0;
            r_idle     <= 1'b1;
            r_done     <= 1'b0;
            r_src_ce   <= 1'b0;
            r_src_addr <= '0;
            r_dst_ce   <= 1'b0;
            r_dst_addr <= '0;
            r_dst_d    <= '0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_src_base <= w_src_base;
            r_dst_base <= w_dst_base;
            r_mode     <= w_mode;
            r_thresh   <= w_thresh;
            r_k        <= w_k;
            r_wk       <= w_wk;
            r_vld      <= w_vld;
            r_idle     <= w_idle;
            r_done     <= w_done;
            r_src_ce   <= w_src_ce;
            r_src_addr <= w_src_addr;
            r_dst_ce   <= w_dst_ce;
            r_dst_addr <= w_dst_addr;
            r_dst_d    <= w_dst_d;
        end
    end

    assign o_idle          = r_idle;
    assign o_read          = r_src_ce;
    assign o_write         = r_dst_ce;
    assign o_done          = r_done;
    assign bram.o_src_ce   = r_src_ce;
    assign bram.o_src_addr = r_src_addr;
    assign bram.o_dst_ce   = r_dst_ce;
    assign bram.o_dst_we   = r_dst_ce;
    assign bram.o_dst_addr = r_dst_addr;
    assign bram.o_dst_d    = r_dst_d;

endmodule
